p_cache_fill_ctrl: RTL

//  Miss/fill sequencer for the direct-mapped program cache feeding the PC/fetch stage.

---
 rtl/p_cache_pkg.sv | 39 +++
 rtl/p_cache_fill_ctrl_p_tag_ram.sv | 55 +++++
 rtl/p_cache_fill_ctrl.sv | 297 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/p_cache_pkg.sv
// ----------------------------------------------------------------------------
// p_cache_pkg
// Shared definitions for the direct-mapped program cache fill controller.
// The package holds the address geometry (word-address width, line offset,
// line index and tag widths), the controller state encoding, and helpers that
// split a word address into its index, tag and offset fields.
// Optional feature macro used by the importing files: EARLY_RESTART_EN.
// ----------------------------------------------------------------------------
package p_cache_pkg;

   localparam int ADDR_W      = 16;
   localparam int DATA_W      = 16;
   localparam int OFFSET_BITS = 3;
   localparam int INDEX_BITS  = 6;
   localparam int TAG_W       = ADDR_W - INDEX_BITS - OFFSET_BITS;
   localparam int LINE_WORDS  = 1 << OFFSET_BITS;
   localparam int NUM_LINES   = 1 << INDEX_BITS;

   typedef enum logic [2:0] {
      IDLE = 3'd0,
      REQ  = 3'd1,
      FILL = 3'd2,
      TAG  = 3'd3,
      INV  = 3'd4
   } state_e;

   function automatic logic [INDEX_BITS-1:0] get_idx(input logic [ADDR_W-1:0] addr);
      return addr[OFFSET_BITS +: INDEX_BITS];
   endfunction

   function automatic logic [TAG_W-1:0] get_tag(input logic [ADDR_W-1:0] addr);
      return addr[ADDR_W-1 -: TAG_W];
   endfunction

   function automatic logic [OFFSET_BITS-1:0] get_off(input logic [ADDR_W-1:0] addr);
      return addr[OFFSET_BITS-1:0];
   endfunction

endpackage

// File: rtl/p_cache_fill_ctrl_p_tag_ram.sv
// ----------------------------------------------------------------------------
// p_tag_ram
// Valid + tag array for the program cache, one entry per line.
// Ports:
//   clk, rst_n           clock, asynchronous active-low reset (clears valid)
//   rd_idx_i             combinational read index
//   rd_valid_o/rd_tag_o  valid bit and tag of the addressed line
//   wr_en_i              write one entry: tag <= wr_tag_i, valid <= wr_valid_i
//   wr_idx_i/wr_tag_i/wr_valid_i  write index, tag and valid value
//   clr_en_i/clr_idx_i   clear the valid bit of one line (wins over write)
// Build macro EARLY_RESTART_EN has no effect on this file.
// ----------------------------------------------------------------------------
module p_tag_ram
   import p_cache_pkg::*;
(
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [INDEX_BITS-1:0] rd_idx_i,
   output logic                  rd_valid_o,
   output logic [TAG_W-1:0]      rd_tag_o,
   input  logic                  wr_en_i,
   input  logic [INDEX_BITS-1:0] wr_idx_i,
   input  logic [TAG_W-1:0]      wr_tag_i,
   input  logic                  wr_valid_i,
   input  logic                  clr_en_i,
   input  logic [INDEX_BITS-1:0] clr_idx_i
);

   logic [NUM_LINES-1:0] valid_q;
   logic [TAG_W-1:0]     tag_q [NUM_LINES];

   // Valid bits: cleared by reset or by the invalidate sweep, set/cleared by a tag write.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         valid_q <= {NUM_LINES{1'b0}};
      end else if (clr_en_i) begin
         valid_q[clr_idx_i] <= 1'b0;
      end else if (wr_en_i) begin
         valid_q[wr_idx_i] <= wr_valid_i;
      end else begin
         valid_q <= valid_q;
      end
   end

   // Tag storage needs no reset: a tag is only ever looked at through its valid bit.
   always_ff @(posedge clk) begin
      if (wr_en_i) begin
         tag_q[wr_idx_i] <= wr_tag_i;
      end
   end

   assign rd_valid_o = valid_q[rd_idx_i];
   assign rd_tag_o   = tag_q[rd_idx_i];

endmodule

// File: rtl/p_cache_fill_ctrl.sv
// ----------------------------------------------------------------------------
// p_cache_fill_ctrl
// Miss/fill sequencer for the direct-mapped program cache feeding fetch.
// Looks the fetch address up in the tag array, stalls fetch on a miss, pulls
// the 8-word line from the SDRAM arbiter as a burst, streams it into the
// external line RAM, then writes the tag. Also sweeps the whole cache invalid.
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   fetch_addr/fetch_en   fetch word address and request
//   inv_all               pulse: invalidate every line
//   mem_req/mem_addr      burst request and line-aligned base to the arbiter
//   mem_gnt               arbiter accepted the request
//   mem_rvalid/mem_rdata  burst data, ascending offset order
//   line_we/line_waddr/line_wdata  line RAM write port {index,offset}
//   p_cache_miss          stall to PC and decoder
//   busy                  controller not idle
//   crit_valid/crit_data  (EARLY_RESTART_EN only) critical word bypass
// Build macro: EARLY_RESTART_EN enables early restart on the missed word.
// ----------------------------------------------------------------------------
module p_cache_fill_ctrl
   import p_cache_pkg::*;
(
   input  logic                              clk,
   input  logic                              rst_n,
   input  logic [ADDR_W-1:0]                 fetch_addr,
   input  logic                              fetch_en,
   input  logic                              inv_all,
   output logic                              mem_req,
   output logic [ADDR_W-1:0]                 mem_addr,
   input  logic                              mem_gnt,
   input  logic                              mem_rvalid,
   input  logic [DATA_W-1:0]                 mem_rdata,
   output logic                              line_we,
   output logic [INDEX_BITS+OFFSET_BITS-1:0] line_waddr,
   output logic [DATA_W-1:0]                 line_wdata,
   output logic                              p_cache_miss,
`ifdef EARLY_RESTART_EN
   output logic                              busy,
   output logic                              crit_valid,
   output logic [DATA_W-1:0]                 crit_data
`else
   output logic                              busy
`endif
);

   localparam logic [OFFSET_BITS-1:0] LAST_WORD = {OFFSET_BITS{1'b1}};
   localparam logic [INDEX_BITS-1:0]  LAST_LINE = {INDEX_BITS{1'b1}};

   state_e                         state_q, state_d;
   logic [ADDR_W-OFFSET_BITS-1:0]  miss_line_q, miss_line_d;
   logic [OFFSET_BITS-1:0]         word_cnt_q, word_cnt_d;
   logic [INDEX_BITS-1:0]          inv_cnt_q, inv_cnt_d;
   logic                           inv_pend_q, inv_pend_d;

   logic                           rd_valid_s;
   logic [TAG_W-1:0]               rd_tag_s;
   logic                           hit_s;
   logic                           last_word_s;
   logic                           inv_req_s;
   logic [ADDR_W-1:0]              miss_base_s;
   logic                           tag_we_s;
   logic                           clr_en_s;

`ifdef EARLY_RESTART_EN
   logic [OFFSET_BITS-1:0]         miss_off_q, miss_off_d;
   logic                           crit_done_q, crit_done_d;
   logic [DATA_W-1:0]              crit_data_q, crit_data_d;
   logic                           crit_hit_s;
`endif

   assign miss_base_s = {miss_line_q, {OFFSET_BITS{1'b0}}};
   assign hit_s       = fetch_en & rd_valid_s & (rd_tag_s == get_tag(fetch_addr));
   assign last_word_s = mem_rvalid & (word_cnt_q == LAST_WORD);
   // An invalidate seen at any point of the fill (including the TAG cycle itself)
   // must keep the freshly filled line from becoming valid.
   assign inv_req_s   = inv_pend_q | inv_all;
   assign tag_we_s    = (state_q == TAG);
   assign clr_en_s    = (state_q == INV);

`ifdef EARLY_RESTART_EN
   assign crit_hit_s  = crit_done_q & fetch_en &
                        (fetch_addr == {miss_line_q, miss_off_q});
   assign crit_data   = crit_data_q;
`endif

   p_tag_ram u_tag_ram (
      .clk        (clk),
      .rst_n      (rst_n),
      .rd_idx_i   (get_idx(fetch_addr)),
      .rd_valid_o (rd_valid_s),
      .rd_tag_o   (rd_tag_s),
      .wr_en_i    (tag_we_s),
      .wr_idx_i   (get_idx(miss_base_s)),
      .wr_tag_i   (get_tag(miss_base_s)),
      .wr_valid_i (~inv_req_s),
      .clr_en_i   (clr_en_s),
      .clr_idx_i  (inv_cnt_q)
   );

   // FSM state register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // FSM next-state logic.
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE: begin
            if (inv_all) begin
               state_d = INV;
            end else if (fetch_en && !hit_s) begin
               state_d = REQ;
            end else begin
               state_d = IDLE;
            end
         end
         REQ: begin
            if (mem_gnt) begin
               state_d = FILL;
            end else begin
               state_d = REQ;
            end
         end
         FILL: begin
            if (last_word_s) begin
               state_d = TAG;
            end else begin
               state_d = FILL;
            end
         end
         TAG: begin
            if (inv_req_s) begin
               state_d = INV;
            end else begin
               state_d = IDLE;
            end
         end
         INV: begin
            if (inv_all) begin
               state_d = INV;
            end else if (inv_cnt_q == LAST_LINE) begin
               state_d = IDLE;
            end else begin
               state_d = INV;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // FSM outputs.
   always_comb begin
      mem_req      = 1'b0;
      line_we      = 1'b0;
      p_cache_miss = 1'b1;
      busy         = 1'b1;
`ifdef EARLY_RESTART_EN
      crit_valid   = 1'b0;
`endif
      case (state_q)
         IDLE: begin
            p_cache_miss = fetch_en & ~hit_s;
            busy         = 1'b0;
         end
         REQ: begin
            mem_req = 1'b1;
         end
         FILL: begin
            line_we = mem_rvalid;
`ifdef EARLY_RESTART_EN
            p_cache_miss = ~crit_hit_s;
            crit_valid   = crit_hit_s;
`else
            p_cache_miss = 1'b1;
`endif
         end
         TAG: begin
            p_cache_miss = 1'b1;
         end
         INV: begin
            p_cache_miss = fetch_en;
         end
         default: begin
            p_cache_miss = 1'b1;
         end
      endcase
   end

   assign mem_addr   = miss_base_s;
   assign line_waddr = {get_idx(miss_base_s), word_cnt_q};
   assign line_wdata = mem_rdata;

   // Miss address, burst word counter, sweep counter and pending-invalidate flag.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         miss_line_q <= {(ADDR_W-OFFSET_BITS){1'b0}};
         word_cnt_q  <= {OFFSET_BITS{1'b0}};
         inv_cnt_q   <= {INDEX_BITS{1'b0}};
         inv_pend_q  <= 1'b0;
      end else begin
         miss_line_q <= miss_line_d;
         word_cnt_q  <= word_cnt_d;
         inv_cnt_q   <= inv_cnt_d;
         inv_pend_q  <= inv_pend_d;
      end
   end

   // Next values of the datapath registers.
   always_comb begin
      miss_line_d = miss_line_q;
      word_cnt_d  = word_cnt_q;
      inv_cnt_d   = inv_cnt_q;
      inv_pend_d  = inv_pend_q;
      case (state_q)
         IDLE: begin
            inv_pend_d = 1'b0;
            if (inv_all) begin
               inv_cnt_d = {INDEX_BITS{1'b0}};
            end else if (fetch_en && !hit_s) begin
               miss_line_d = fetch_addr[ADDR_W-1:OFFSET_BITS];
            end else begin
               miss_line_d = miss_line_q;
            end
         end
         REQ: begin
            inv_pend_d = inv_req_s;
            if (mem_gnt) begin
               word_cnt_d = {OFFSET_BITS{1'b0}};
            end else begin
               word_cnt_d = word_cnt_q;
            end
         end
         FILL: begin
            inv_pend_d = inv_req_s;
            if (mem_rvalid) begin
               word_cnt_d = word_cnt_q + OFFSET_BITS'(1);
            end else begin
               word_cnt_d = word_cnt_q;
            end
         end
         TAG: begin
            inv_pend_d = 1'b0;
            inv_cnt_d  = {INDEX_BITS{1'b0}};
         end
         INV: begin
            inv_pend_d = 1'b0;
            // A new inv_all restarts the sweep; the last line wraps the count to 0.
            if (inv_all) begin
               inv_cnt_d = {INDEX_BITS{1'b0}};
            end else begin
               inv_cnt_d = inv_cnt_q + INDEX_BITS'(1);
            end
         end
         default: begin
            inv_pend_d = 1'b0;
         end
      endcase
   end

`ifdef EARLY_RESTART_EN
   // Critical-word tracking for the early-restart bypass.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         miss_off_q  <= {OFFSET_BITS{1'b0}};
         crit_done_q <= 1'b0;
         crit_data_q <= {DATA_W{1'b0}};
      end else begin
         miss_off_q  <= miss_off_d;
         crit_done_q <= crit_done_d;
         crit_data_q <= crit_data_d;
      end
   end

   // Capture the missed word as it streams past in the burst.
   always_comb begin
      miss_off_d  = miss_off_q;
      crit_done_d = crit_done_q;
      crit_data_d = crit_data_q;
      if (state_q == IDLE && !inv_all && fetch_en && !hit_s) begin
         miss_off_d = get_off(fetch_addr);
      end else if (state_q == REQ && mem_gnt) begin
         crit_done_d = 1'b0;
      end else if (state_q == FILL && mem_rvalid && word_cnt_q == miss_off_q) begin
         crit_done_d = 1'b1;
         crit_data_d = mem_rdata;
      end else begin
         crit_done_d = crit_done_q;
      end
   end
`endif

endmodule
